serial_adder: RTL and testbench

- Bit-serial, multi-cycle adder that sits upstream of the team's single-bit full-adder cell (a, b, c -> sum, carry).
- Accepts two WIDTH-bit operands plus carry-in through a start/done handshake.
- Feeds one bit pair per clock, LSB first, through an internal full-adder and registers the carry between bits.
- Presents the WIDTH-bit sum and carry-out, held stable until the next operation.

---
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around a single full-adder cell.
// Operands are captured on an accepted start, then one bit pair per clock
// is summed LSB first with the carry held in a flop between bits. The
// completed sum and carry-out are published together on the final bit and
// held until the next operation completes.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_s;
  logic             bit_c;
  logic             start_ok;
  logic [WIDTH-1:0] psum_next;

  // Full-adder cell: sum bit
  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  // Full-adder cell: carry is the majority of the three inputs
  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign bit_s     = fa_sum(sa[0], sb[0], carry);
  assign bit_c     = fa_carry(sa[0], sb[0], carry);
  // Start is only honoured when no addition is in flight.
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  // The new bit enters at the MSB so that after WIDTH shifts bit 0 is the first bit computed.
  assign psum_next = {bit_s, psum[WIDTH-1:1]};

  // Control FSM and serial datapath; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (start_ok) begin
      sa    <= a;
      sb    <= b;
      carry <= cin;
      cnt   <= '0;
      state <= RUN;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          carry <= bit_c;
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          psum  <= psum_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            sum   <= psum_next;
            cout  <= bit_c;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder against
// a plain-arithmetic model ({cout,sum} = a + b + cin, WIDTH cycles latency).
module tb_serial_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp;
  int n_err;
  int cyc_cnt;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full operation: pulse start, scramble inputs, wait for done, compare with a+b+cin.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input string tag, output bit ok);
    int cyc;
    int nbusy;
    int e0;
    int expv;
    e0    = n_err;
    expv  = int'(ta) + int'(tb_v) + int'(tc);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    cyc   = 0;
    nbusy = 0;
    while (!done && cyc < W + 4) begin
      if (busy) nbusy++;
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(W));
    check({tag, " busy_cycles"}, 64'(nbusy), 64'(W));
    check({tag, " result"}, 64'({cout, sum}), 64'(expv));
    ok = (n_err == e0);
  endtask

  initial begin
    bit ok;
    bit sweep_bad;
    int cyc;
    int ndone;
    int t_first;
    int t_second;
    logic [W:0] got;

    n_cmp   = 0;
    n_err   = 0;
    cyc_cnt = 0;
    rst_n   = 1'b0;
    start   = 1'($urandom);
    a       = W'($urandom);
    b       = W'($urandom);
    cin     = 1'($urandom);

    // Reset with random inputs
    repeat (3) begin
      tick();
      start = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
    end
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst sum", 64'(sum), 64'(0));
    check("rst cout", 64'(cout), 64'(0));
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle busy", 64'(busy), 64'(0));
    check("idle done", 64'(done), 64'(0));
    check("idle result", 64'({cout, sum}), 64'(0));

    // Single add: 9 + 6 + 1 = 16 -> sum 0, cout 1, then hold
    do_add(4'd9, 4'd6, 1'b1, "single", ok);
    check("single sum", 64'(sum), 64'(0));
    check("single cout", 64'(cout), 64'(1));
    ndone = 0;
    repeat (4) begin
      tick();
      if (done) ndone++;
    end
    check("single extra_done", 64'(ndone), 64'(0));
    check("single hold", 64'({cout, sum}), 64'(16));

    // Boundary operands
    do_add('1, '1, 1'b1, "ones", ok);
    check("ones sum", 64'(sum), 64'((1 << W) - 1));
    do_add('0, '0, 1'b0, "zeros", ok);
    check("zeros result", 64'({cout, sum}), 64'(0));

    // Exhaustive sweep, stopping at the first wrong case
    sweep_bad = 1'b0;
    for (int i = 0; i < 512 && !sweep_bad; i++) begin
      do_add(W'(i >> 5), W'(i >> 1), 1'(i), "sweep", ok);
      if (!ok) sweep_bad = 1'b1;
    end

    // Start while busy is ignored
    a = 4'd3; b = 4'd4; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd15; b = 4'd15; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    got   = '0;
    repeat (3 * W) begin
      if (done) begin
        ndone++;
        got = {cout, sum};
      end
      tick();
    end
    check("busy_start done_count", 64'(ndone), 64'(1));
    check("busy_start result", 64'(got), 64'(7));
    check("busy_start hold", 64'({cout, sum}), 64'(7));

    // Back-to-back with start held high
    a = 4'd1; b = 4'd2; cin = 1'b0; start = 1'b1;
    tick();
    cyc = 0;
    while (!done && cyc < W + 4) begin tick(); cyc++; end
    check("b2b first latency", 64'(cyc), 64'(W));
    check("b2b first result", 64'({cout, sum}), 64'(3));
    t_first = cyc_cnt;
    a = 4'd15; b = 4'd15; cin = 1'b1;
    tick();
    start = 1'b0;
    check("b2b rerun busy", 64'(busy), 64'(1));
    cyc = 0;
    while (!done && cyc < W + 4) begin tick(); cyc++; end
    t_second = cyc_cnt;
    check("b2b spacing", 64'(t_second - t_first), 64'(W + 1));
    check("b2b second result", 64'({cout, sum}), 64'(31));

    // Reset mid-RUN
    a = 4'd7; b = 4'd8; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("midrun pre busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrun rst busy", 64'(busy), 64'(0));
    check("midrun rst done", 64'(done), 64'(0));
    check("midrun rst result", 64'({cout, sum}), 64'(0));
    ndone = 0;
    repeat (W) begin
      tick();
      if (done) ndone++;
    end
    check("midrun no_done", 64'(ndone), 64'(0));
    rst_n = 1'b1;
    tick();
    do_add(4'd2, 4'd2, 1'b0, "after_rst", ok);
    check("after_rst sum", 64'(sum), 64'(4));

    // Reset asserted during DONE
    a = 4'd5; b = 4'd6; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < W + 4) begin tick(); cyc++; end
    check("done_rst pre done", 64'(done), 64'(1));
    rst_n = 1'b0;
    #1;
    check("done_rst done", 64'(done), 64'(0));
    check("done_rst result", 64'({cout, sum}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized operations with random idle gaps
    for (int k = 0; k < 150; k++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom), "random", ok);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
